// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
// Holds the FSM state encoding, the func3 load/store width codes and a beat-count helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Bytes moved per access; unknown codes fall back to a full word.
  function automatic logic [2:0] beat_count(input logic [2:0] width);
    case (width[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + MEM stage), the arbiter and the byte-wide RAM.
// The slave modport is the arbiter's view; master is the pipeline/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_cancel;
  logic                  if_ack;
  logic [31:0]           if_inst;
  logic                  ma_req;
  logic                  ma_we;
  logic [2:0]            ma_width;
  logic [ADDR_WIDTH-1:0] ma_addr;
  logic [31:0]           ma_wdata;
  logic                  ma_ack;
  logic [31:0]           ma_rdata;
  logic                  if_stall_req;
  logic                  ma_stall_req;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  modport slave (
    input  if_req, if_addr, if_cancel, ma_req, ma_we, ma_width, ma_addr, ma_wdata, mem_din,
    output if_ack, if_inst, ma_ack, ma_rdata, if_stall_req, ma_stall_req, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, if_cancel, ma_req, ma_we, ma_width, ma_addr, ma_wdata, mem_din,
    input  if_ack, if_inst, ma_ack, ma_rdata, if_stall_req, ma_stall_req, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter_load_extend.sv
// Assembles the little-endian load word from captured bytes plus the byte arriving this cycle,
// then sign- or zero-extends it according to func3.
module mem_arbiter_load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [3:0][7:0] bytes_i,
  input  logic [7:0]      last_byte_i,
  input  logic [1:0]      last_idx_i,
  input  logic [2:0]      width_i,
  output logic [31:0]     data_o
);
  logic [3:0][7:0] asm_word;

  // The final byte is still on mem_din at the completing edge, so it bypasses the buffer.
  always_comb begin
    asm_word             = bytes_i;
    asm_word[last_idx_i] = last_byte_i;
  end

  always_comb begin
    case (width_i)
      F3_B:    data_o = {{24{asm_word[0][7]}}, asm_word[0]};
      F3_H:    data_o = {{16{asm_word[1][7]}}, asm_word[1], asm_word[0]};
      F3_BU:   data_o = {24'h0, asm_word[0]};
      F3_HU:   data_o = {16'h0, asm_word[1], asm_word[0]};
      default: data_o = asm_word;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one byte-wide RAM port,
// serialising each access into little-endian byte beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);
  arb_state_e            state_q;
  logic [2:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [31:0]           wdata_q;
  logic [2:0]            width_q;
  logic                  fetch_q;
  logic                  mem_wr_q;
  logic [7:0]            mem_dout_q;
  logic                  if_ack_q;
  logic                  ma_ack_q;
  logic [31:0]           if_inst_q;
  logic [31:0]           ma_rdata_q;
  logic [3:0][7:0]       rbuf_q;

  logic        if_want, ma_want, grant_ma, grant_if;
  logic [2:0]  n_beats, cnt_d;
  logic [31:0] load_word;

  // A port whose ack is showing this cycle still has its request up; it must not be re-granted.
  assign if_want  = bus.if_req && !if_ack_q;
  assign ma_want  = bus.ma_req && !ma_ack_q;
  assign grant_ma = ma_want && (DATA_PRIORITY || !if_want);
  assign grant_if = if_want && !grant_ma;
  assign n_beats  = beat_count(width_q);
  assign cnt_d    = cnt_q + 3'd1;

  mem_arbiter_load_extend u_load_extend (
    .bytes_i     (rbuf_q),
    .last_byte_i (bus.mem_din),
    .last_idx_i  (2'(n_beats - 3'd1)),
    .width_i     (width_q),
    .data_o      (load_word)
  );

  // NOTE: every register, including the small read buffer, is reset so a mid-access reset leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_a_q    <= '0;
      wdata_q    <= '0;
      width_q    <= '0;
      fetch_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      if_ack_q   <= 1'b0;
      ma_ack_q   <= 1'b0;
      if_inst_q  <= '0;
      ma_rdata_q <= '0;
      rbuf_q     <= '0;
    end else if (rdy) begin
      if_ack_q <= 1'b0;
      ma_ack_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          cnt_q <= '0;
          if (grant_ma) begin
            fetch_q  <= 1'b0;
            addr_q   <= bus.ma_addr;
            mem_a_q  <= bus.ma_addr;
            width_q  <= bus.ma_width;
            wdata_q  <= bus.ma_wdata;
            mem_wr_q <= bus.ma_we;
            if (bus.ma_we) mem_dout_q <= bus.ma_wdata[7:0];
            state_q  <= bus.ma_we ? ARB_WRITE : ARB_READ;
          end else if (grant_if) begin
            fetch_q <= 1'b1;
            addr_q  <= bus.if_addr;
            mem_a_q <= bus.if_addr;
            width_q <= F3_W;
            state_q <= ARB_READ;
          end
        end
        ARB_WRITE: begin
          if (cnt_q == n_beats - 3'd1) begin
            mem_wr_q <= 1'b0;
            ma_ack_q <= 1'b1;
            state_q  <= ARB_IDLE;
          end else begin
            cnt_q      <= cnt_d;
            mem_a_q    <= addr_q + ADDR_WIDTH'(cnt_d);
            mem_dout_q <= wdata_q[{cnt_d[1:0], 3'b000} +: 8];
          end
        end
        ARB_READ: begin
          if (fetch_q && bus.if_cancel) begin
            state_q <= ARB_IDLE;
          end else if (cnt_q == n_beats) begin
            if (fetch_q) begin
              if_ack_q  <= 1'b1;
              if_inst_q <= load_word;
            end else begin
              ma_ack_q   <= 1'b1;
              ma_rdata_q <= load_word;
            end
            state_q <= ARB_IDLE;
          end else begin
            // RAM data lags the address by one cycle, so byte k lands while address k+1 is out.
            if (cnt_q != 3'd0) rbuf_q[2'(cnt_q - 3'd1)] <= bus.mem_din;
            if (cnt_d < n_beats) mem_a_q <= addr_q + ADDR_WIDTH'(cnt_d);
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.if_ack       = if_ack_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.ma_ack       = ma_ack_q;
  assign bus.ma_rdata     = ma_rdata_q;
  assign bus.if_stall_req = bus.if_req && !if_ack_q;
  assign bus.ma_stall_req = bus.ma_req && !ma_ack_q;
  assign bus.mem_a        = mem_a_q;
  assign bus.mem_dout     = mem_dout_q;
  assign bus.mem_wr       = mem_wr_q && rdy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural byte RAM, per-port expected-ack queues
// with due cycles, a write log, and directed fetch/load/store/tie/cancel/freeze/reset cases.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_PRIORITY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct { logic [31:0] data; bit chk; int due; } exp_t;
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;

  exp_t if_exp[$];
  exp_t ma_exp[$];
  wr_t  wr_log[$];

  bit [7:0]    ram [4096];
  logic        pre_we   = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read byte RAM, frozen together with the arbiter when rdy is low.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (rdy) begin
      bus.mem_din <= ram[bus.mem_a[11:0]];
      if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Acks are popped against the scoreboard on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.if_ack) begin
        if (if_exp.size() == 0) check("if_ack_spurious", 32'd1, 32'd0);
        else begin
          e = if_exp.pop_front();
          check("if_inst", bus.if_inst, e.data);
          check("if_ack_cycle", cyc, e.due);
        end
      end
      if (bus.ma_ack) begin
        if (ma_exp.size() == 0) check("ma_ack_spurious", 32'd1, 32'd0);
        else begin
          e = ma_exp.pop_front();
          if (e.chk) check("ma_rdata", bus.ma_rdata, e.data);
          check("ma_ack_cycle", cyc, e.due);
        end
      end
      if (bus.mem_wr) wr_log.push_back('{cyc, bus.mem_a, bus.mem_dout});
    end
  end

  function automatic int nbeats(input logic [2:0] w);
    if (w[1:0] == 2'b00) return 1;
    if (w[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue_if(input logic [31:0] a, input logic [31:0] d, input int extra);
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = a;
    e.data = d; e.chk = 1'b1; e.due = cyc + 6 + extra;
    if_exp.push_back(e);
  endtask

  task automatic issue_ma(input logic we, input logic [2:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] d, input int extra);
    exp_t e;
    bus.ma_req = 1'b1; bus.ma_we = we; bus.ma_width = w; bus.ma_addr = a; bus.ma_wdata = wd;
    e.data = d; e.chk = !we; e.due = cyc + 1 + nbeats(w) + (we ? 0 : 1) + extra;
    ma_exp.push_back(e);
  endtask

  // Holds requests until their ack, checking the stall outputs every cycle on the way.
  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.if_req || bus.ma_req) && n < budget) begin
      @(negedge clk); #1;
      n++;
      check("if_stall", {31'b0, bus.if_stall_req}, {31'b0, bus.if_req && if_exp.size() != 0});
      check("ma_stall", {31'b0, bus.ma_stall_req}, {31'b0, bus.ma_req && ma_exp.size() != 0});
      if (bus.if_ack) bus.if_req = 1'b0;
      if (bus.ma_ack) bus.ma_req = 1'b0;
    end
    if (bus.if_req || bus.ma_req) begin
      check("ack_timeout", {30'b0, bus.if_req, bus.ma_req}, 32'd0);
      bus.if_req = 1'b0; bus.ma_req = 1'b0;
      if_exp.delete(); ma_exp.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int wl, c0;
    logic [31:0] sw_data;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_cancel = 1'b0;
    bus.ma_req = 1'b0; bus.ma_we = 1'b0; bus.ma_width = '0; bus.ma_addr = '0; bus.ma_wdata = '0;

    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
    poke(12'h200, 8'h93); poke(12'h201, 8'h00); poke(12'h202, 8'h10); poke(12'h203, 8'h00);
    poke(12'hFFE, 8'h11); poke(12'hFFF, 8'h22); poke(12'h000, 8'h33); poke(12'h001, 8'h44);
    poke(12'h020, 8'h80); poke(12'h021, 8'hFF);

    @(negedge clk);
    check("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    check("rst_if_ack", {31'b0, bus.if_ack}, 32'd0);
    check("rst_ma_ack", {31'b0, bus.ma_ack}, 32'd0);
    check("rst_if_inst", bus.if_inst, 32'd0);
    check("rst_ma_rdata", bus.ma_rdata, 32'd0);
    rst = 1'b0;

    // Plain fetch, then a fetch whose byte addresses wrap past the top of the space.
    @(negedge clk); wl = wr_log.size();
    issue_if(32'h100, 32'h0000_0513, 0); wait_idle(20);
    check("fetch_no_write", wr_log.size(), wl);
    @(negedge clk); issue_if(32'hFFFF_FFFE, 32'h4433_2211, 0); wait_idle(20);

    // Loads with every extension mode.
    @(negedge clk); issue_ma(1'b0, F3_B,  32'h20, '0, 32'hFFFF_FF80, 0); wait_idle(20);
    @(negedge clk); issue_ma(1'b0, F3_BU, 32'h20, '0, 32'h0000_0080, 0); wait_idle(20);
    @(negedge clk); issue_ma(1'b0, F3_H,  32'h20, '0, 32'hFFFF_FF80, 0); wait_idle(20);
    @(negedge clk); issue_ma(1'b0, F3_HU, 32'h20, '0, 32'h0000_FF80, 0); wait_idle(20);

    // Stores: beat-by-beat trace for SW, RAM contents for SB/SH.
    sw_data = 32'hDEAD_BEEF;
    @(negedge clk); wl = wr_log.size(); c0 = cyc;
    issue_ma(1'b1, F3_W, 32'h40, sw_data, '0, 0); wait_idle(20);
    check("sw_beats", wr_log.size() - wl, 32'd4);
    if (wr_log.size() - wl == 4)
      for (int k = 0; k < 4; k++) begin
        check("sw_addr", wr_log[wl+k].a, 32'h40 + k);
        check("sw_byte", {24'b0, wr_log[wl+k].d}, {24'b0, sw_data[8*k +: 8]});
        check("sw_cycle", wr_log[wl+k].cyc, c0 + 1 + k);
      end
    @(negedge clk); issue_ma(1'b1, F3_B, 32'h50, 32'h1234_56A5, '0, 0); wait_idle(20);
    @(negedge clk); issue_ma(1'b1, F3_H, 32'h60, 32'h0000_CAFE, '0, 0); wait_idle(20);
    check("sb_byte0", {24'b0, ram[12'h050]}, 32'hA5);
    check("sb_byte1", {24'b0, ram[12'h051]}, 32'h00);
    check("sh_bytes", {16'b0, ram[12'h061], ram[12'h060]}, 32'hCAFE);
    check("sh_byte2", {24'b0, ram[12'h062]}, 32'h00);
    @(negedge clk); issue_ma(1'b0, F3_H,  32'h60, '0, 32'hFFFF_CAFE, 0); wait_idle(20);
    @(negedge clk); issue_ma(1'b0, F3_BU, 32'h50, '0, 32'h0000_00A5, 0); wait_idle(20);

    // Same-cycle tie: data first, fetch address on the bus the cycle after ma_ack.
    @(negedge clk);
    issue_ma(1'b0, F3_W, 32'h40, '0, 32'hDEAD_BEEF, 0);
    issue_if(32'h100, 32'h0000_0513, 6);
    fork
      wait_idle(30);
      begin repeat (7) @(negedge clk); #1; check("tie_fetch_addr", bus.mem_a, 32'h100); end
    join

    // Fetch cancelled during beat 2, then a fresh fetch.
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h100;
    repeat (3) @(negedge clk);
    check("cancel_beat2_addr", bus.mem_a, 32'h102);
    bus.if_cancel = 1'b1; bus.if_req = 1'b0;
    @(negedge clk); bus.if_cancel = 1'b0;
    repeat (6) begin @(negedge clk); check("cancel_no_ack", {31'b0, bus.if_ack}, 32'd0); end
    @(negedge clk); issue_if(32'h200, 32'h0010_0093, 0); wait_idle(20);

    // rdy low for three cycles in the middle of a word load.
    @(negedge clk); issue_ma(1'b0, F3_W, 32'h40, '0, 32'hDEAD_BEEF, 3);
    fork
      begin repeat (2) @(negedge clk); rdy = 1'b0; repeat (3) @(negedge clk); rdy = 1'b1; end
      wait_idle(30);
    join

    // Reset during beat 1 of a word store.
    @(negedge clk);
    bus.ma_req = 1'b1; bus.ma_we = 1'b1; bus.ma_width = F3_W;
    bus.ma_addr = 32'h300; bus.ma_wdata = 32'h1122_3344;
    repeat (2) @(negedge clk);
    check("sw_beat1_wr", {31'b0, bus.mem_wr}, 32'd1);
    check("sw_beat1_addr", bus.mem_a, 32'h301);
    rst = 1'b1; #1;
    check("arst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check("arst_mem_a", bus.mem_a, 32'd0);
    check("arst_mem_dout", {24'b0, bus.mem_dout}, 32'd0);
    check("arst_if_inst", bus.if_inst, 32'd0);
    check("arst_ma_rdata", bus.ma_rdata, 32'd0);
    check("arst_ma_ack", {31'b0, bus.ma_ack}, 32'd0);
    bus.ma_req = 1'b0; #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_beat0_kept", {24'b0, ram[12'h300]}, 32'h44);
    check("arst_beat1_lost", {24'b0, ram[12'h301]}, 32'h00);
    @(negedge clk); issue_ma(1'b0, F3_BU, 32'h50, '0, 32'h0000_00A5, 0); wait_idle(20);

    repeat (4) @(negedge clk);
    check("sb_leftover", if_exp.size() + ma_exp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
